// File: rtl/dc_wcs_if.sv
// dc_wcs_if: microsequencer read bus and loader handshake for the writable control store.
// DC_WCS_PARITY_EN adds par_err/inj_err.
interface dc_wcs_if #(
    parameter int AW  = 10,
    parameter int NAW = 9,
    parameter int MCW = 16
);
    logic [AW-1:0]      a_in;
    logic               rd_en;
    logic [NAW-1:0]     ma;
    logic [MCW-1:0]     mc;
    logic               rd_vld;
    logic               ld_req;
    logic [AW-1:0]      ld_addr;
    logic [NAW+MCW-1:0] ld_data;
    logic               ld_ack;
    logic               ld_busy;
`ifdef DC_WCS_PARITY_EN
    logic               par_err;
    logic               inj_err;
    modport master (output a_in, rd_en, ld_req, ld_addr, ld_data, inj_err,
                    input ma, mc, rd_vld, ld_ack, ld_busy, par_err);
    modport slave  (input a_in, rd_en, ld_req, ld_addr, ld_data, inj_err,
                    output ma, mc, rd_vld, ld_ack, ld_busy, par_err);
`else
    modport master (output a_in, rd_en, ld_req, ld_addr, ld_data,
                    input ma, mc, rd_vld, ld_ack, ld_busy);
    modport slave  (input a_in, rd_en, ld_req, ld_addr, ld_data,
                    output ma, mc, rd_vld, ld_ack, ld_busy);
`endif
endinterface

// File: rtl/dc_wcs.sv
// dc_wcs: writable control store with registered reads, AX remap and a req/ack loader.
// DC_WCS_PARITY_EN adds an even-parity bit per word, sticky par_err and the inj_err hook.
module dc_wcs #(
    parameter int DC303_ROM = 0,
    parameter int AW        = 10,
    parameter int NAW       = 9,
    parameter int MCW       = 16,
    parameter int RMP_LO    = 4,
    parameter int RMP_W     = 3
) (
    input logic     pin_clk,
    input logic     pin_rst_n,
    dc_wcs_if.slave bus
);
    localparam int DW    = NAW + MCW;
    localparam int DEPTH = 1 << (AW - 1);
`ifdef DC_WCS_PARITY_EN
    localparam int W = DW + 1;
`else
    localparam int W = DW;
`endif
    typedef logic [W-1:0] mem_t [DEPTH];
    typedef enum logic [1:0] {IDLE, PEND, ACK, HOLD} st_t;

    // Images 0..2 hold a sequential next-address chain with opcode i*3 + image*4096; image 3 is blank.
    function automatic mem_t init_mem();
        logic [DW-1:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = (DC303_ROM == 3) ? '0 : {NAW'(i + 1), MCW'(i * 3 + DC303_ROM * 4096)};
`ifdef DC_WCS_PARITY_EN
            init_mem[i] = {^w, w};
`else
            init_mem[i] = w;
`endif
        end
    endfunction

    function automatic logic [AW-2:0] remap(input logic [AW-1:0] a);
        return (a[AW-1] && &a[RMP_LO+RMP_W-1:RMP_LO])
            ? {(AW-1-RMP_LO)'(a[AW-2:RMP_LO+RMP_W]), a[RMP_LO-1:0]}
            : a[AW-2:0];
    endfunction

    mem_t mem = init_mem();

    st_t            st_q;
    logic           ack_q, busy_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  data_q;
    logic [W-1:0]   rd_word, wr_word;
    logic [DW-1:0]  word_d, word_q;
    logic           vld_d, vld_q;
    logic           wr_en;
    logic           perr_d, perr_q;

    always_comb begin
        rd_word = mem[remap(bus.a_in)];
        word_d  = bus.rd_en ? rd_word[DW-1:0] : word_q;
        vld_d   = bus.rd_en;
        wr_en   = (st_q == PEND) && !bus.rd_en;
`ifdef DC_WCS_PARITY_EN
        wr_word = {^data_q ^ bus.inj_err, data_q};
        perr_d  = perr_q | (bus.rd_en & ^rd_word);
`else
        wr_word = data_q;
        perr_d  = 1'b0;
`endif
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n)
        if (!pin_rst_n) begin
            word_q <= '0;
            vld_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            word_q <= word_d;
            vld_q  <= vld_d;
            perr_q <= perr_d;
        end

    // Contents are deliberately not reset so run-time patches survive a reset.
    always_ff @(posedge pin_clk)
        if (wr_en) mem[remap(addr_q)] <= wr_word;

    always_ff @(posedge pin_clk or negedge pin_rst_n)
        if (!pin_rst_n) begin
            st_q   <= IDLE;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (st_q)
                IDLE: if (bus.ld_req) begin
                    addr_q <= bus.ld_addr;
                    data_q <= bus.ld_data;
                    busy_q <= 1'b1;
                    st_q   <= PEND;
                end
                PEND: if (!bus.rd_en) begin
                    ack_q <= 1'b1;
                    st_q  <= ACK;
                end
                ACK:  st_q <= HOLD;
                HOLD: if (!bus.ld_req) begin
                    busy_q <= 1'b0;
                    st_q   <= IDLE;
                end
                default: st_q <= IDLE;
            endcase
        end

    assign bus.ma      = word_q[DW-1:MCW];
    assign bus.mc      = word_q[MCW-1:0];
    assign bus.rd_vld  = vld_q;
    assign bus.ld_ack  = ack_q;
    assign bus.ld_busy = busy_q;
`ifdef DC_WCS_PARITY_EN
    assign bus.par_err = perr_q;
`endif
endmodule
